dmem_mmio_bridge: RTL and testbench

Data-memory-side bridge placed directly downstream of the core's DMEM port: it decodes every core data access into either the data BRAM or a small memory-mapped I/O region, and returns read data with the same one-cycle latency as the BRAM. The MMIO region holds a transmit FIFO feeding an 8N1 UART transmitter, a status register and a free-running cycle counter. This gives the core console output and timing without changing the core itself.

---
 rtl/toast_mmio_pkg.sv | 22 ++
 rtl/uart_tx.sv | 95 +++++++++
 rtl/dmem_mmio_bridge.sv | 136 +++++++++++++
 tb/tb_dmem_mmio_bridge.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toast_mmio_pkg.sv
// Shared definitions for the DMEM/MMIO bridge: register map, status bits, UART states.
package toast_mmio_pkg;

  // Word offsets within the MMIO page (addr[11:2]); byte offsets 0x000/0x004/0x008.
  localparam logic [9:0] OFF_TXDATA = 10'h000;
  localparam logic [9:0] OFF_STATUS = 10'h001;
  localparam logic [9:0] OFF_CYCLE  = 10'h002;

  // STATUS register bit positions.
  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one start bit, eight data bits LSB first, one stop bit.
module uart_tx
  import toast_mmio_pkg::*;
#(
  parameter int CLK_DIV = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       busy
);

  localparam int            CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);

  uart_state_t   state_q;
  logic [CW-1:0] baud_cnt_q;
  logic [7:0]    shift_q;
  logic [2:0]    bit_idx_q;
  logic          baud_done;

  assign baud_done = (baud_cnt_q == BAUD_LAST);
  // A byte is taken when idle, or on the last stop-bit cycle so frames run back to back.
  assign tx_ready  = (state_q == IDLE) || ((state_q == STOP) && baud_done);
  assign busy      = (state_q != IDLE);

  // Frame sequencer with baud counter; txd is registered so the line never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      txd        <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          baud_cnt_q <= '0;
          if (tx_valid) begin
            state_q <= START;
            shift_q <= tx_byte;
            txd     <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            state_q    <= DATA;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            txd        <= shift_q[0];
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
              txd     <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              shift_q   <= shift_q >> 1;
              txd       <= shift_q[1];
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_cnt_q <= '0;
            if (tx_valid) begin
              state_q <= START;
              shift_q <= tx_byte;
              txd     <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          txd     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/dmem_mmio_bridge.sv
// Splits core data accesses between the data BRAM and a small MMIO page
// (UART TX FIFO, status, cycle counter) with matching one-cycle read latency.
module dmem_mmio_bridge
  import toast_mmio_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000,
  parameter int          CLK_DIV    = 868,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [31:0] DMEM_addr,
  input  logic [3:0]  DMEM_wr_byte_en,
  input  logic [31:0] DMEM_wr_data,
  input  logic        DMEM_wr_en,
  input  logic        DMEM_rst,
  output logic [31:0] DMEM_rd_data,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_wr_byte_en,
  output logic [31:0] ram_wr_data,
  output logic        ram_wr_en,
  output logic        ram_rst,
  input  logic [31:0] ram_rd_data,
  output logic        uart_txd
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic        mmio_sel;
  logic [9:0]  reg_off;
  logic        mmio_wr;
  logic        push_req;
  logic        push;
  logic        pop;
  logic        ovf_set;
  logic        ovf_clr;
  logic        fifo_full;
  logic        fifo_empty;
  logic        tx_ready;
  logic        tx_busy;
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        overflow_q;
  logic [31:0] cycle_q;
  logic        select_q;
  logic [31:0] mmio_rd_q;
  logic [31:0] mmio_rd_next;

  assign mmio_sel = (DMEM_addr[31:12] == MMIO_BASE[31:12]);
  assign reg_off  = DMEM_addr[11:2];

  // BRAM side is a straight copy; only stores to the MMIO page are blocked.
  assign ram_addr       = DMEM_addr;
  assign ram_wr_byte_en = DMEM_wr_byte_en;
  assign ram_wr_data    = DMEM_wr_data;
  assign ram_wr_en      = DMEM_wr_en & ~mmio_sel;
  assign ram_rst        = DMEM_rst;

  assign mmio_wr  = DMEM_wr_en & mmio_sel & DMEM_wr_byte_en[0];
  assign push_req = mmio_wr && (reg_off == OFF_TXDATA);
  assign ovf_clr  = mmio_wr && (reg_off == OFF_STATUS) && DMEM_wr_data[STAT_OVF];

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = ~fifo_empty & tx_ready;
  // A pop frees the slot being written, so push-while-full is fine when popping.
  assign push       = push_req & (~fifo_full | pop);
  assign ovf_set    = push_req & fifo_full & ~pop;

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q[AW-1:0]] <= DMEM_wr_data[7:0];
    end
  end

  // FIFO pointers, sticky overflow flag (set wins over clear) and cycle counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      cycle_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (ovf_set)      overflow_q <= 1'b1;
      else if (ovf_clr) overflow_q <= 1'b0;
      cycle_q <= cycle_q + 32'd1;
    end
  end

  // MMIO read decode from current register state (before this edge's updates).
  always_comb begin
    mmio_rd_next = '0;
    case (reg_off)
      OFF_STATUS: begin
        mmio_rd_next[STAT_FULL]  = fifo_full;
        mmio_rd_next[STAT_EMPTY] = fifo_empty;
        mmio_rd_next[STAT_BUSY]  = tx_busy;
        mmio_rd_next[STAT_OVF]   = overflow_q;
      end
      OFF_CYCLE: mmio_rd_next = cycle_q;
      default:   mmio_rd_next = '0;
    endcase
  end

  // Register the source select and MMIO data so loads line up with BRAM latency.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      select_q  <= 1'b0;
      mmio_rd_q <= '0;
    end else begin
      select_q  <= mmio_sel;
      mmio_rd_q <= mmio_sel ? mmio_rd_next : '0;
    end
  end

  assign DMEM_rd_data = select_q ? mmio_rd_q : ram_rd_data;

  uart_tx #(
    .CLK_DIV(CLK_DIV)
  ) u_uart_tx (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .tx_byte (fifo_mem[rd_ptr_q[AW-1:0]]),
    .tx_valid(~fifo_empty),
    .tx_ready(tx_ready),
    .txd     (uart_txd),
    .busy    (tx_busy)
  );

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Bench for dmem_mmio_bridge: vector table for decode/read path, scoreboards for
// load data and UART bytes, hand sequences for FIFO, overflow and reset corners.
module tb_dmem_mmio_bridge;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam logic [31:0] A_TX   = 32'h8000_0000;
  localparam logic [31:0] A_STAT = 32'h8000_0004;
  localparam logic [31:0] A_CYC  = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] dmem_addr = '0;
  logic [3:0]  dmem_be = '0;
  logic [31:0] dmem_wdata = '0;
  logic        dmem_we = 1'b0;
  logic        dmem_rst = 1'b0;
  logic [31:0] dmem_rd_data;
  logic [31:0] ram_addr;
  logic [3:0]  ram_wr_byte_en;
  logic [31:0] ram_wr_data;
  logic        ram_wr_en;
  logic        ram_rst;
  logic [31:0] ram_rd_data = 32'h0;
  logic        uart_txd;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int rel_cyc = 0;

  typedef struct {
    logic [31:0] exp;
    int          due;
    string       name;
  } rd_exp_t;
  rd_exp_t    rd_q[$];
  logic [7:0] exp_tx_q[$];

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic        rd;
    logic [31:0] exp_rd;
    logic        exp_ram_we;
    string       name;
  } vec_t;
  vec_t vecs [17];

  always #5 clk = ~clk;

  dmem_mmio_bridge #(
    .MMIO_BASE (32'h8000_0000),
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .Clk            (clk),
    .Reset_n        (rst_n),
    .DMEM_addr      (dmem_addr),
    .DMEM_wr_byte_en(dmem_be),
    .DMEM_wr_data   (dmem_wdata),
    .DMEM_wr_en     (dmem_we),
    .DMEM_rst       (dmem_rst),
    .DMEM_rd_data   (dmem_rd_data),
    .ram_addr       (ram_addr),
    .ram_wr_byte_en (ram_wr_byte_en),
    .ram_wr_data    (ram_wr_data),
    .ram_wr_en      (ram_wr_en),
    .ram_rst        (ram_rst),
    .ram_rd_data    (ram_rd_data),
    .uart_txd       (uart_txd)
  );

  // Simple one-cycle-latency BRAM model; word 0 preloaded as a canary.
  logic [31:0] ram_mem [0:63] = '{0: 32'h1357_9BDF, default: 32'h0};
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_wr_en && ram_wr_byte_en[b]) ram_mem[ram_addr[7:2]][8*b +: 8] <= ram_wr_data[8*b +: 8];
    end
    if (ram_rst) ram_rd_data <= 32'h0;
    else         ram_rd_data <= ram_mem[ram_addr[7:2]];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    end
  endtask

  // Load-data scoreboard: entries are due one clock after their address cycle.
  rd_exp_t rd_mon_e;
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
      rd_mon_e = rd_q.pop_front();
      check({rd_mon_e.name, " rd_data"}, dmem_rd_data, rd_mon_e.exp);
    end
  end

  // Serial-line receiver: samples mid-bit, aborts a frame if reset is seen.
  logic [9:0] rx_frame;
  bit         rx_aborted;
  logic [7:0] rx_exp;
  initial forever begin
    @(posedge clk);
    #1;
    if (rst_n && uart_txd === 1'b0) begin
      rx_aborted = 1'b0;
      rx_frame   = '0;
      for (int o = 1; o <= 38; o++) begin
        @(posedge clk);
        #1;
        if (!rst_n) rx_aborted = 1'b1;
        if (o % 4 == 2) rx_frame[(o - 2) / 4] = uart_txd;
      end
      if (!rx_aborted) begin
        if (exp_tx_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL rx_unexpected: got frame 0x%03h, required no frame", rx_frame);
        end else begin
          rx_exp = exp_tx_q.pop_front();
          check("rx_frame", 32'({rx_frame[9], rx_frame[0], rx_frame[8:1]}),
                32'({1'b1, 1'b0, rx_exp}));
        end
      end
    end
  end

  // One bus cycle: drive at negedge, check pass-through, queue expected load data.
  task automatic access(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                        input logic we, input logic rd, input logic [31:0] exp_rd,
                        input logic cyc_rel, input logic exp_ram_we, input string nm);
    rd_exp_t e;
    @(negedge clk);
    dmem_addr  = a;
    dmem_be    = be;
    dmem_wdata = d;
    dmem_we    = we;
    #1;
    check({nm, " ram_wr_en"}, 32'(ram_wr_en), 32'(exp_ram_we));
    check({nm, " ram_addr"}, ram_addr, a);
    if (rd) begin
      e.exp  = cyc_rel ? 32'(cyc - rel_cyc) : exp_rd;
      e.due  = cyc + 1;
      e.name = nm;
      rd_q.push_back(e);
    end
    @(posedge clk);
    #1;
    dmem_we    = 1'b0;
    dmem_be    = '0;
    dmem_addr  = '0;
    dmem_wdata = '0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    access(a, 4'h0, 32'h0, 1'b0, 1'b1, exp, 1'b0, 1'b0, nm);
  endtask

  task automatic push_byte(input logic [7:0] b, input bit expect_tx);
    access(A_TX, 4'h1, {24'h0, b}, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, "push");
    if (expect_tx) exp_tx_q.push_back(b);
  endtask

  task automatic idle(input int n);
    repeat (n) access(32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, "idle");
  endtask

  task automatic wait_drain(input int bound, input string nm);
    int n;
    n = 0;
    while (exp_tx_q.size() > 0 && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({nm, " drain_left"}, 32'(exp_tx_q.size()), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset txd", 32'(uart_txd), 32'h1);
    repeat (3) @(posedge clk);
    #1;
    check("reset rd_data follows ram", dmem_rd_data, 32'h1357_9BDF);
    @(negedge clk);
    rst_n = 1'b1;
    rel_cyc = cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, required finish before 100000");
    $fatal(1, "watchdog");
  end

  logic [7:0] a5 = 8'hA5;
  logic       lvl;

  initial begin
    vecs[0]  = '{A_STAT,        4'h0, 32'h0,         1'b0, 1'b1, 32'h2,         1'b0, "status_after_reset"};
    vecs[1]  = '{32'h0000_0010, 4'hF, 32'h1234_5678, 1'b1, 1'b0, 32'h0,         1'b1, "ram_wr_10"};
    vecs[2]  = '{32'h0000_0010, 4'h0, 32'h0,         1'b0, 1'b1, 32'h1234_5678, 1'b0, "ram_rd_10"};
    vecs[3]  = '{32'h0000_0014, 4'h3, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,         1'b1, "ram_wr_14_half"};
    vecs[4]  = '{32'h0000_0014, 4'h0, 32'h0,         1'b0, 1'b1, 32'h0000_BEEF, 1'b0, "ram_rd_14"};
    vecs[5]  = '{A_TX,          4'h0, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, "txdata_reads_0"};
    vecs[6]  = '{32'h8000_0010, 4'h0, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, "unmapped_rd"};
    vecs[7]  = '{32'h8000_0010, 4'hF, 32'h0000_00FF, 1'b1, 1'b0, 32'h0,         1'b0, "unmapped_wr"};
    vecs[8]  = '{32'h0000_0010, 4'h0, 32'h0,         1'b0, 1'b1, 32'h1234_5678, 1'b0, "ram_untouched_by_mmio"};
    vecs[9]  = '{32'h8000_0FFC, 4'h0, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, "mmio_top_rd"};
    vecs[10] = '{32'h8000_1020, 4'hF, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0,         1'b1, "ram_above_page_wr"};
    vecs[11] = '{32'h8000_1020, 4'h0, 32'h0,         1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, "ram_above_page_rd"};
    vecs[12] = '{A_STAT,        4'hF, 32'h0000_0008, 1'b1, 1'b0, 32'h0,         1'b0, "status_clr_idle"};
    vecs[13] = '{A_STAT,        4'h0, 32'h0,         1'b0, 1'b1, 32'h2,         1'b0, "status_still_2"};
    vecs[14] = '{32'h7FFF_F010, 4'h0, 32'h0,         1'b0, 1'b1, 32'h1234_5678, 1'b0, "ram_below_page_rd"};
    vecs[15] = '{A_TX,          4'h2, 32'h0000_5A5A, 1'b1, 1'b0, 32'h0,         1'b0, "tx_wr_no_be0"};
    vecs[16] = '{A_STAT,        4'h0, 32'h0,         1'b0, 1'b1, 32'h2,         1'b0, "status_no_push"};

    do_reset();

    for (int i = 0; i < 17; i++) begin
      access(vecs[i].addr, vecs[i].be, vecs[i].wdata, vecs[i].we, vecs[i].rd,
             vecs[i].exp_rd, 1'b0, vecs[i].exp_ram_we, vecs[i].name);
    end
    idle(2);

    // Single byte 0xA5: exact per-cycle waveform, 40 cycles.
    push_byte(8'hA5, 1'b1);
    check("a5 txd before pop", 32'(uart_txd), 32'h1);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (i < 4)       lvl = 1'b0;
      else if (i < 36) lvl = a5[(i - 4) / 4];
      else             lvl = 1'b1;
      check($sformatf("a5 txd cycle %0d", i), 32'(uart_txd), 32'(lvl));
    end
    wait_drain(20, "a5");
    idle(2);
    rd(A_STAT, 32'h2, "status_after_a5");

    // CYCLE counter: two loads ten cycles apart.
    access(A_CYC, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, "cycle_1");
    idle(9);
    access(A_CYC, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, "cycle_2");

    // Six back-to-back pushes: one pops, four buffer, the sixth overflows.
    push_byte(8'h11, 1'b1);
    push_byte(8'h22, 1'b1);
    push_byte(8'h33, 1'b1);
    push_byte(8'h44, 1'b1);
    push_byte(8'h55, 1'b1);
    push_byte(8'h66, 1'b0);
    rd(A_STAT, 32'hD, "status_overflow");
    access(A_STAT, 4'h1, 32'h8, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, "status_clr");
    rd(A_STAT, 32'h5, "status_cleared");
    wait_drain(260, "overflow");
    idle(4);
    rd(A_STAT, 32'h2, "status_after_overflow");

    // Push exactly on the pop edge while full: accepted, no overflow.
    push_byte(8'hA1, 1'b1);
    push_byte(8'hA2, 1'b1);
    push_byte(8'hA3, 1'b1);
    push_byte(8'hA4, 1'b1);
    push_byte(8'hA5, 1'b1);
    rd(A_STAT, 32'h5, "status_full");
    idle(35);
    push_byte(8'hA6, 1'b1);
    rd(A_STAT, 32'h5, "status_full_no_ovf");
    wait_drain(300, "push_pop_full");
    idle(4);
    rd(A_STAT, 32'h2, "status_after_push_pop");

    // Reset pulse in the middle of a data bit.
    push_byte(8'h00, 1'b0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("txd data bit before reset", 32'(uart_txd), 32'h0);
    rst_n = 1'b0;
    #1;
    check("txd async reset", 32'(uart_txd), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    rel_cyc = cyc;
    rd(A_STAT, 32'h2, "status_after_mid_reset");
    idle(60);
    check("txd idle after reset", 32'(uart_txd), 32'h1);

    rd(32'h0000_0000, 32'h1357_9BDF, "ram_word0_intact");
    idle(2);
    check("rd scoreboard left", 32'(rd_q.size()), 32'h0);
    check("tx scoreboard left", 32'(exp_tx_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
